// File: rtl/arm_control_unit_pkg.sv
// Shared encodings for the ARM-subset control unit: condition codes, opcode
// classes, ALU operation codes and data-processing command codes.
package arm_ctrl_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
    COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
    COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
    COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
  } cond_e;

  typedef enum logic [1:0] {
    OP_DP    = 2'b00,
    OP_MEM   = 2'b01,
    OP_BR    = 2'b10,
    OP_UNDEF = 2'b11
  } op_e;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_ORR = 4'b0011;
  localparam logic [3:0] ALU_LSL = 4'b0100;
  localparam logic [3:0] ALU_LSR = 4'b0101;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_LSL = 4'b1101;
  localparam logic [3:0] CMD_LSR = 4'b1110;

endpackage

// File: rtl/arm_control_unit_if.sv
// Instruction-field inputs and datapath-control outputs of the control unit.
// The slave modport is the control unit; the master modport is fetch/datapath.
interface arm_control_unit_if;
  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic [3:0] alu_flags;
  logic       pc_src;
  logic       mem_to_reg;
  logic       mem_write;
  logic [3:0] alu_control;
  logic       alu_src;
  logic       reg_write;
  logic [1:0] reg_src;

  modport master (
    output cond, op, funct, rd, alu_flags,
    input  pc_src, mem_to_reg, mem_write, alu_control, alu_src, reg_write, reg_src
  );

  modport slave (
    input  cond, op, funct, rd, alu_flags,
    output pc_src, mem_to_reg, mem_write, alu_control, alu_src, reg_write, reg_src
  );
endinterface

// File: rtl/arm_control_unit_cond_logic.sv
// NZCV flag register plus the ARM condition table; flags written in one cycle
// are seen by cond_ex only from the next cycle.
module cond_logic
  import arm_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic [1:0] flag_write,
  output logic       cond_ex
);

  logic [3:0] r_flags;
  logic       w_n, w_z, w_c, w_v;

  assign {w_n, w_z, w_c, w_v} = r_flags;

  // Condition evaluation against the registered flags.
  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      COND_EQ: cond_ex = w_z;
      COND_NE: cond_ex = ~w_z;
      COND_CS: cond_ex = w_c;
      COND_CC: cond_ex = ~w_c;
      COND_MI: cond_ex = w_n;
      COND_PL: cond_ex = ~w_n;
      COND_VS: cond_ex = w_v;
      COND_VC: cond_ex = ~w_v;
      COND_HI: cond_ex = w_c & ~w_z;
      COND_LS: cond_ex = ~w_c | w_z;
      COND_GE: cond_ex = (w_n == w_v);
      COND_LT: cond_ex = (w_n != w_v);
      COND_GT: cond_ex = ~w_z & (w_n == w_v);
      COND_LE: cond_ex = w_z | (w_n != w_v);
      COND_AL: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // Flag register: N,Z and C,V halves update independently, only when the condition passes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_flags <= 4'b0000;
    end else begin
      if (flag_write[1] & cond_ex) r_flags[3:2] <= alu_flags[3:2];
      if (flag_write[0] & cond_ex) r_flags[1:0] <= alu_flags[1:0];
    end
  end

endmodule

// File: rtl/arm_control_unit.sv
// Control unit for the single-cycle ARM-subset CPU: main decoder plus condition gating.
// Define CU_BRANCH_LINK_EN to let BL (branch with funct[4]=1) write the link register.
module arm_control_unit
  import arm_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  arm_control_unit_if.slave    bus
);

  logic       w_dec_reg_write;
  logic       w_dec_mem_write;
  logic       w_branch;
  logic       w_mem_to_reg;
  logic       w_alu_src;
  logic [3:0] w_alu_control;
  logic [1:0] w_reg_src;
  logic [1:0] w_flag_write;
  logic       w_cond_ex;
  logic [3:0] w_cmd;

  assign w_cmd = bus.funct[4:1];

  // Main decoder: instruction class and command to raw datapath controls.
  always_comb begin
    w_dec_reg_write = 1'b0;
    w_dec_mem_write = 1'b0;
    w_branch        = 1'b0;
    w_mem_to_reg    = 1'b0;
    w_alu_src       = 1'b0;
    w_alu_control   = ALU_ADD;
    w_reg_src       = 2'b00;
    w_flag_write    = 2'b00;
    case (op_e'(bus.op))
      OP_DP: begin
        w_alu_src       = bus.funct[5];
        w_dec_reg_write = 1'b1;
        w_flag_write[1] = bus.funct[0];
        w_flag_write[0] = bus.funct[0] & ((w_cmd == CMD_ADD) | (w_cmd == CMD_SUB));
        case (w_cmd)
          CMD_ADD: w_alu_control = ALU_ADD;
          CMD_SUB: w_alu_control = ALU_SUB;
          CMD_AND: w_alu_control = ALU_AND;
          CMD_ORR: w_alu_control = ALU_ORR;
          CMD_LSL: w_alu_control = ALU_LSL;
          CMD_LSR: w_alu_control = ALU_LSR;
          default: begin
            w_alu_control   = ALU_ADD;
            w_dec_reg_write = 1'b0;
          end
        endcase
      end
      OP_MEM: begin
        w_alu_src     = 1'b1;
        w_alu_control = bus.funct[3] ? ALU_ADD : ALU_SUB;
        if (bus.funct[0]) begin
          w_dec_reg_write = 1'b1;
          w_mem_to_reg    = 1'b1;
        end else begin
          w_dec_mem_write = 1'b1;
          w_reg_src       = 2'b10;
        end
      end
      OP_BR: begin
        w_alu_control = ALU_ADD;
        w_alu_src     = 1'b1;
        w_reg_src     = 2'b01;
        w_branch      = 1'b1;
`ifdef CU_BRANCH_LINK_EN
        w_dec_reg_write = bus.funct[4];
`else
        w_dec_reg_write = 1'b0;
`endif
      end
      default: begin
        w_dec_reg_write = 1'b0;
      end
    endcase
  end

  cond_logic u_cond_logic (
    .clk        (clk),
    .reset      (reset),
    .cond       (bus.cond),
    .alu_flags  (bus.alu_flags),
    .flag_write (w_flag_write),
    .cond_ex    (w_cond_ex)
  );

  // Architectural writes are suppressed on a failed condition and throughout reset.
  assign bus.reg_write   = w_dec_reg_write & w_cond_ex & ~reset;
  assign bus.mem_write   = w_dec_mem_write & w_cond_ex & ~reset;
  assign bus.pc_src      = (w_branch | ((bus.rd == 4'hF) & w_dec_reg_write)) & w_cond_ex & ~reset;
  assign bus.mem_to_reg  = w_mem_to_reg;
  assign bus.alu_control = w_alu_control;
  assign bus.alu_src     = w_alu_src;
  assign bus.reg_src     = w_reg_src;

endmodule

// File: tb/tb_arm_control_unit.sv
// Directed self-checking bench for arm_control_unit; outputs are packed as
// {pc_src, mem_to_reg, mem_write, alu_control[3:0], alu_src, reg_write, reg_src[1:0]}.
module tb_arm_control_unit;

  logic clk;
  logic reset;
  int   n_asserts;
  int   n_fail;

  arm_control_unit_if bus ();

  arm_control_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic rst, input logic [3:0] c, input logic [1:0] o,
                       input logic [5:0] f, input logic [3:0] r, input logic [3:0] af);
    @(negedge clk);
    reset         = rst;
    bus.cond      = c;
    bus.op        = o;
    bus.funct     = f;
    bus.rd        = r;
    bus.alu_flags = af;
    #1;
  endtask

  task automatic chk(input string tag, input logic [10:0] exp_v);
    logic [10:0] obs;
    obs = {bus.pc_src, bus.mem_to_reg, bus.mem_write, bus.alu_control,
           bus.alu_src, bus.reg_write, bus.reg_src};
    n_asserts++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
    end
  endtask

  initial begin
    n_asserts = 0;
    n_fail    = 0;

    // Reset cycle with an AL ADDS #imm on the bus: writes forced off.
    reset = 1'b1;
    bus.cond = 4'hE; bus.op = 2'b00; bus.funct = 6'b101001; bus.rd = 4'h0; bus.alu_flags = 4'b0000;
    #1;
    chk("reset_adds", 11'b0_0_0_0000_1_0_00);

    drive(1'b0, 4'hE, 2'b00, 6'b101001, 4'h1, 4'b0000);
    chk("al_adds", 11'b0_0_0_0000_1_1_00);

    // EQ with Z=0 fails; its flag update (V=1) must not happen.
    drive(1'b0, 4'h0, 2'b00, 6'b101001, 4'h1, 4'b0001);
    chk("eq_fail", 11'b0_0_0_0000_1_0_00);
    drive(1'b0, 4'h6, 2'b00, 6'b101000, 4'h1, 4'b0000);
    chk("vs_after_fail", 11'b0_0_0_0000_1_0_00);

    // AL ANDS loads Z; EQ passes next cycle. flags -> 0100
    drive(1'b0, 4'hE, 2'b00, 6'b100001, 4'h2, 4'b0100);
    chk("al_ands", 11'b0_0_0_0010_1_1_00);
    drive(1'b0, 4'h0, 2'b00, 6'b101000, 4'h2, 4'b0000);
    chk("eq_pass", 11'b0_0_0_0000_1_1_00);

    // ALU op coverage with chained conditions. flags -> 0010, 0010, 0110, 1010
    drive(1'b0, 4'hE, 2'b00, 6'b100101, 4'h3, 4'b0010);
    chk("al_subs", 11'b0_0_0_0001_1_1_00);
    drive(1'b0, 4'hE, 2'b00, 6'b111001, 4'h3, 4'b0000);
    chk("al_orrs", 11'b0_0_0_0011_1_1_00);
    drive(1'b0, 4'h8, 2'b00, 6'b111011, 4'h3, 4'b0100);
    chk("hi_lsls", 11'b0_0_0_0100_1_1_00);
    drive(1'b0, 4'h9, 2'b00, 6'b111101, 4'h3, 4'b1000);
    chk("ls_lsrs", 11'b0_0_0_0101_1_1_00);

    // ANDS with 1011 must leave C,V = 10. flags -> 1010
    drive(1'b0, 4'hB, 2'b00, 6'b100001, 4'h4, 4'b1011);
    chk("lt_ands", 11'b0_0_0_0010_1_1_00);
    drive(1'b0, 4'h6, 2'b00, 6'b101000, 4'h4, 4'b0000);
    chk("vs_cv_kept", 11'b0_0_0_0000_1_0_00);
    drive(1'b0, 4'h2, 2'b00, 6'b101000, 4'h4, 4'b0000);
    chk("cs_cv_kept", 11'b0_0_0_0000_1_1_00);
    drive(1'b0, 4'h4, 2'b00, 6'b101000, 4'h4, 4'b0000);
    chk("mi_pass", 11'b0_0_0_0000_1_1_00);
    drive(1'b0, 4'hC, 2'b00, 6'b101000, 4'h4, 4'b0000);
    chk("gt_fail", 11'b0_0_0_0000_1_0_00);
    drive(1'b0, 4'hD, 2'b00, 6'b101000, 4'h4, 4'b0000);
    chk("le_pass", 11'b0_0_0_0000_1_1_00);

    // Memory instructions.
    drive(1'b0, 4'hE, 2'b01, 6'b011000, 4'h5, 4'b0000);
    chk("str", 11'b0_0_1_0000_1_0_10);
    drive(1'b0, 4'hE, 2'b01, 6'b011001, 4'h5, 4'b0000);
    chk("ldr", 11'b0_1_0_0000_1_1_00);
    drive(1'b0, 4'hE, 2'b01, 6'b010001, 4'h5, 4'b0000);
    chk("ldr_sub", 11'b0_1_0_0001_1_1_00);

    // Branches and writes to R15.
    drive(1'b0, 4'hE, 2'b10, 6'b000000, 4'h0, 4'b0000);
    chk("b_al", 11'b1_0_0_0000_1_0_01);
    drive(1'b0, 4'hE, 2'b10, 6'b010000, 4'h0, 4'b0000);
`ifdef CU_BRANCH_LINK_EN
    chk("bl_al", 11'b1_0_0_0000_1_1_01);
`else
    chk("bl_al", 11'b1_0_0_0000_1_0_01);
`endif
    drive(1'b0, 4'hE, 2'b00, 6'b101000, 4'hF, 4'b0000);
    chk("add_r15", 11'b1_0_0_0000_1_1_00);
    drive(1'b0, 4'hF, 2'b10, 6'b000000, 4'h0, 4'b0000);
    chk("b_nv", 11'b0_0_0_0000_1_0_01);
    drive(1'b0, 4'hF, 2'b00, 6'b101000, 4'hF, 4'b0000);
    chk("add_r15_nv", 11'b0_0_0_0000_1_0_00);

    // Undefined op and unsupported DP command.
    drive(1'b0, 4'hE, 2'b11, 6'b111111, 4'hF, 4'b0000);
    chk("undef", 11'b0_0_0_0000_0_0_00);
    drive(1'b0, 4'hE, 2'b00, 6'b000010, 4'hF, 4'b0000);
    chk("bad_cmd", 11'b0_0_0_0000_0_0_00);

    // Mid-sequence reset with AL STR; flags must read 0000 afterwards.
    drive(1'b1, 4'hE, 2'b01, 6'b011000, 4'h5, 4'b1111);
    chk("reset_str", 11'b0_0_0_0000_1_0_10);
    drive(1'b0, 4'hE, 2'b01, 6'b011000, 4'h5, 4'b0000);
    chk("str_after_rst", 11'b0_0_1_0000_1_0_10);
    drive(1'b0, 4'h4, 2'b00, 6'b101000, 4'h6, 4'b0000);
    chk("mi_after_rst", 11'b0_0_0_0000_1_0_00);
    drive(1'b0, 4'h2, 2'b00, 6'b101000, 4'h6, 4'b0000);
    chk("cs_after_rst", 11'b0_0_0_0000_1_0_00);
    drive(1'b0, 4'h0, 2'b00, 6'b101000, 4'h6, 4'b0000);
    chk("eq_after_rst", 11'b0_0_0_0000_1_0_00);
    drive(1'b0, 4'h5, 2'b00, 6'b101000, 4'h6, 4'b0000);
    chk("pl_after_rst", 11'b0_0_0_0000_1_1_00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
